// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one product or quotient bit per clock,
// with RISC-V divide-by-zero/overflow results and a flush for squashed instructions.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [1:0]       flags
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             state, state_next;
   logic [CW-1:0]      count;
   logic [2:0]         op_q;
   logic               neg_q;
   logic               special_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [WIDTH-1:0]   rem_q;
   logic [2*WIDTH-1:0] prod_q;

   logic               signed_a, signed_b, sign_a, sign_b, neg_res;
   logic               div_zero, div_ovf, special, last_iter;
   logic [WIDTH-1:0]   mag_a, mag_b, special_res;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               q_bit;
   logic [2*WIDTH-1:0] prod_next, prod_signed;
   logic [WIDTH-1:0]   quot_next, rem_next, quot_final, rem_final, calc_res;

   function automatic logic [1:0] flags_of(input logic [WIDTH-1:0] v);
      return {v == '0, v[WIDTH-1]};
   endfunction

   // Accept-time decode: operand signedness, magnitudes and the RISC-V special results
   always_comb begin
      signed_a    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
      signed_b    = op[2] ? ~op[0] : ~op[1];
      sign_a      = signed_a & a[WIDTH-1];
      sign_b      = signed_b & b[WIDTH-1];
      mag_a       = sign_a ? -a : a;
      mag_b       = sign_b ? -b : b;
      neg_res     = (op[2] & op[1]) ? sign_a : (sign_a ^ sign_b);
      div_zero    = op[2] && (b == '0);
      div_ovf     = op[2] && !op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
      special     = div_zero || div_ovf;
      special_res = '0;
      if (div_zero)
         special_res = op[1] ? a : '1;
      else
         special_res = op[1] ? '0 : a;
   end

   // One shift-add multiply step and one restoring divide step, plus final sign fix-up
   always_comb begin
      addend      = prod_q[0] ? opnd_q : '0;
      mul_sum     = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      prod_next   = {mul_sum, prod_q[WIDTH-1:1]};
      prod_signed = neg_q ? -prod_next : prod_next;

      div_shift   = {rem_q, prod_q[WIDTH-1]};
      q_bit       = (div_shift >= {1'b0, opnd_q});
      rem_next    = q_bit ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
      quot_next   = {prod_q[WIDTH-2:0], q_bit};
      quot_final  = neg_q ? -quot_next : quot_next;
      rem_final   = neg_q ? -rem_next : rem_next;

      calc_res    = '0;
      if (special_q)
         calc_res = opnd_q;
      else if (op_q[2])
         calc_res = op_q[1] ? rem_final : quot_final;
      else if (op_q[1:0] == 2'b00)
         calc_res = prod_signed[WIDTH-1:0];
      else
         calc_res = prod_signed[2*WIDTH-1:WIDTH];

      last_iter = special_q || (count == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      in_ready   = (state == IDLE);
      out_valid  = (state == DONE);
      case (state)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (last_iter) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush)
         state_next = IDLE;
   end

   // Special cases still take one CALC cycle so every result is registered by the same path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count     <= '0;
         op_q      <= '0;
         neg_q     <= 1'b0;
         special_q <= 1'b0;
         opnd_q    <= '0;
         rem_q     <= '0;
         prod_q    <= '0;
         result    <= '0;
         flags     <= '0;
      end else if (!flush) begin
         if (state == IDLE && in_valid) begin
            op_q      <= op;
            neg_q     <= neg_res;
            special_q <= special;
            count     <= '0;
            rem_q     <= '0;
            if (special)
               opnd_q <= special_res;
            else
               opnd_q <= op[2] ? mag_b : mag_a;
            prod_q    <= {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
         end else if (state == CALC) begin
            count  <= count + 1'b1;
            rem_q  <= rem_next;
            prod_q <= op_q[2] ? {prod_q[2*WIDTH-1:WIDTH], quot_next} : prod_next;
            if (last_iter) begin
               result <= calc_res;
               flags  <= flags_of(calc_res);
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, randomized ops
// against a 64-bit arithmetic model, and handshake/flush/reset sequences.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
   logic [2:0]    op;
   logic [W-1:0]  a, b, result;
   logic [1:0]    flags;

   int numCompared   = 0;
   int numMismatched = 0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flags(flags)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expRes;
      logic [1:0]  expFlags;
      int          expLat;
   } vec_t;

   vec_t vecs[17];

   // Reference model: RV32M semantics computed with plain 64-bit arithmetic
   function automatic logic [31:0] refResult(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, p;
      longint unsigned ux, uy, up;
      sx = $signed(x);
      sy = $signed(y);
      ux = x;
      uy = y;
      case (o)
         3'b000: begin p = sx * sy; return p[31:0]; end
         3'b001: begin p = sx * sy; return p[63:32]; end
         3'b010: begin p = sx * longint'(uy); return p[63:32]; end
         3'b011: begin up = ux * uy; return up[63:32]; end
         3'b100: begin
            if (y == 0) return 32'hFFFFFFFF;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
            p = sx / sy;
            return p[31:0];
         end
         3'b101: begin
            if (y == 0) return 32'hFFFFFFFF;
            return x / y;
         end
         3'b110: begin
            if (y == 0) return x;
            if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
            p = sx % sy;
            return p[31:0];
         end
         default: begin
            if (y == 0) return x;
            return x % y;
         end
      endcase
   endfunction

   function automatic logic [1:0] refFlags(input logic [31:0] v);
      return {v == 32'h0, v[31]};
   endfunction

   function automatic int refLatency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      if (o[2] && y == 0) return 1;
      if ((o == 3'b100 || o == 3'b110) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
      return W;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      numCompared++;
      if (actual !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic startOp(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      int n;
      n = 0;
      op = o;
      a = x;
      b = y;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("accept_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitResult(output int lat);
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!out_valid && lat < 200);
      checkOutput("out_valid_seen", {31'b0, out_valid}, 32'd1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] res, output logic [1:0] fl, output int lat);
      startOp(o, x, y);
      waitResult(lat);
      res = result;
      fl  = flags;
      drain();
   endtask

   initial begin
      logic [31:0] res, ra, rb, expRes;
      logic [1:0]  fl;
      logic [2:0]  ro;
      int          lat, cnt, kind;

      vecs[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 2'b01, 32};
      vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 2'b00, 32};
      vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2'b01, 32};
      vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32};
      vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 2'b01, 32};
      vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 2'b01, 32};
      vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       2'b00, 32};
      vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        2'b00, 32};
      vecs[8]  = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2'b01, 1};
      vecs[9]  = '{3'b111, 32'd5,        32'd0,        32'd5,        2'b00, 1};
      vecs[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2'b01, 1};
      vecs[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2'b10, 1};
      vecs[12] = '{3'b000, 32'h12345678, 32'h00000000, 32'h00000000, 2'b10, 32};
      vecs[13] = '{3'b100, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 2'b01, 1};
      vecs[14] = '{3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2'b10, 32};
      vecs[15] = '{3'b110, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 2'b00, 32};
      vecs[16] = '{3'b001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 2'b01, 32};

      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      op        = '0;
      a         = '0;
      b         = '0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      #1;
      checkOutput("reset_in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("reset_result",    result,             32'd0);
      checkOutput("reset_flags",     {30'b0, flags},     32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, res, fl, lat);
         checkOutput($sformatf("vec%0d_result", i), res, vecs[i].expRes);
         checkOutput($sformatf("vec%0d_flags", i), {30'b0, fl}, {30'b0, vecs[i].expFlags});
         checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
      end

      // Randomized operations, biased toward divide corner cases
      for (int i = 0; i < 60; i++) begin
         ro   = 3'($urandom_range(0, 7));
         ra   = $urandom;
         rb   = $urandom;
         kind = $urandom_range(0, 9);
         if (kind == 0) rb = 32'h0;
         if (kind == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
         if (kind == 2) rb = $urandom_range(1, 15);
         if (kind == 3) ra = $urandom_range(0, 100);
         expRes = refResult(ro, ra, rb);
         applyStimulus(ro, ra, rb, res, fl, lat);
         checkOutput($sformatf("rand%0d_op%0d_result", i, ro), res, expRes);
         checkOutput($sformatf("rand%0d_flags", i), {30'b0, fl}, {30'b0, refFlags(expRes)});
         checkOutput($sformatf("rand%0d_latency", i), lat, refLatency(ro, ra, rb));
      end

      // Backpressure in DONE, then a request accepted right after the drain
      startOp(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF);
      waitResult(lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         checkOutput("hold_result",    result,             32'hFFFFFFFE);
         checkOutput("hold_flags",     {30'b0, flags},     32'd1);
         checkOutput("hold_out_valid", {31'b0, out_valid}, 32'd1);
         checkOutput("hold_in_ready",  {31'b0, in_ready},  32'd0);
      end
      op = 3'b101;
      a = 32'd100;
      b = 32'd7;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("drain_in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("drain_out_valid", {31'b0, out_valid}, 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("b2b_accepted", {31'b0, in_ready}, 32'd0);
      waitResult(lat);
      checkOutput("b2b_result",  result, 32'd14);
      checkOutput("b2b_latency", lat,    32'd32);
      drain();

      // Operands and in_valid changing after accept must not disturb the operation
      startOp(3'b000, 32'h7, 32'hFFFFFFFD);
      op = 3'b100;
      a = 32'hDEADBEEF;
      b = 32'h00012345;
      in_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitResult(lat);
      checkOutput("late_operand_result", result, 32'hFFFFFFEB);
      drain();

      // Flush on the tenth CALC cycle
      startOp(3'b101, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      checkOutput("flush_in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("flush_out_valid", {31'b0, out_valid}, 32'd0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) cnt++;
      end
      checkOutput("flush_never_valid", cnt, 32'd0);
      applyStimulus(3'b110, 32'hFFFFFFF9, 32'h2, res, fl, lat);
      checkOutput("post_flush_result", res, 32'hFFFFFFFF);
      checkOutput("post_flush_flags",  {30'b0, fl}, 32'd1);

      // Flush while a result waits in DONE, even with out_ready and in_valid high
      startOp(3'b000, 32'd3, 32'd5);
      waitResult(lat);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      flush     = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      checkOutput("flush_done_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("flush_done_in_ready",  {31'b0, in_ready},  32'd1);
      @(posedge clk);
      #1;
      checkOutput("flush_done_stays_idle", {31'b0, in_ready}, 32'd1);

      // Asynchronous reset mid-CALC, away from any clock edge
      startOp(3'b100, 32'd12345, 32'd67);
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
      checkOutput("async_rst_in_ready",  {31'b0, in_ready},  32'd1);
      checkOutput("async_rst_result",    result,             32'd0);
      checkOutput("async_rst_flags",     {30'b0, flags},     32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(3'b101, 32'd100, 32'd7, res, fl, lat);
      checkOutput("post_rst_result",  res, 32'd14);
      checkOutput("post_rst_latency", lat, 32'd32);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
